// File: rtl/gelato_l1_icache.sv
// gelato_l1_icache
//   Direct-mapped, read-only L1 instruction cache. Responder end of the
//   gelato_l1_icache_if fetch protocol: one word fetch at a time, hits served
//   from local tag/data arrays, misses refilled by a line burst from L2/memory.
//
// Ports
//   clk, rst            clock; synchronous active-high reset (priority over rdy)
//   rdy                 global enable; 0 freezes all state and outputs
//   icache_valid/addr   fetch request and byte address (addr[1:0] ignored)
//   icache_ready/data   one-cycle response pulse with instruction word
//   flush               invalidate all lines (honoured in IDLE only)
//   mem_req_*           line refill request (line-aligned address)
//   mem_resp_*          refill beats, ascending word order, gaps allowed
//   perf_hit_cnt/perf_miss_cnt  only when GELATO_ICACHE_PERF_EN is defined
//
// Optional feature macro: GELATO_ICACHE_PERF_EN (hit/miss counters).
module gelato_l1_icache #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_LINES  = 64,
  parameter int LINE_WORDS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rdy,
  input  logic                  icache_valid,
  input  logic [ADDR_WIDTH-1:0] icache_addr,
  output logic                  icache_ready,
  output logic [DATA_WIDTH-1:0] icache_data,
  input  logic                  flush,
  output logic                  mem_req_valid,
  input  logic                  mem_req_ready,
  output logic [ADDR_WIDTH-1:0] mem_req_addr,
  input  logic                  mem_resp_valid,
  input  logic [DATA_WIDTH-1:0] mem_resp_data
`ifdef GELATO_ICACHE_PERF_EN
  ,
  output logic [31:0]           perf_hit_cnt,
  output logic [31:0]           perf_miss_cnt
`endif
);

  localparam int OFF_W = $clog2(LINE_WORDS);
  localparam int IDX_W = $clog2(NUM_LINES);
  localparam int TAG_W = ADDR_WIDTH - IDX_W - OFF_W - 2;
  localparam logic [OFF_W-1:0] LAST_BEAT = OFF_W'(LINE_WORDS - 1);

  typedef enum logic [2:0] {
    IDLE, LOOKUP, REFILL_REQ, REFILL_WAIT, RESP, DRAIN
  } state_e;

  state_e state_q, state_d;

  logic [TAG_W-1:0]      tag_q, tag_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [OFF_W-1:0]      off_q, off_d;
  logic [OFF_W-1:0]      beat_q, beat_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [ADDR_WIDTH-1:0] req_addr_q, req_addr_d;
  logic [NUM_LINES-1:0]  valid_q, valid_d;

  // Arrays without reset; line validity lives in valid_q.
  logic [TAG_W-1:0]      tag_mem  [NUM_LINES];
  logic [DATA_WIDTH-1:0] data_mem [NUM_LINES*LINE_WORDS];
  logic [TAG_W-1:0]      rd_tag_q;
  logic [DATA_WIDTH-1:0] rd_word_q;

  logic [OFF_W-1:0] in_off;
  logic [IDX_W-1:0] in_idx;
  logic [TAG_W-1:0] in_tag;
  logic             accept, hit, beat_wr, last_beat;

  assign in_off = icache_addr[OFF_W+1:2];
  assign in_idx = icache_addr[OFF_W+2 +: IDX_W];
  assign in_tag = icache_addr[ADDR_WIDTH-1 -: TAG_W];

  // A flush in IDLE wins over a simultaneous request; the request is
  // picked up on the following cycle because the requester keeps it held.
  assign accept    = (state_q == IDLE) && !flush && icache_valid;
  assign hit       = valid_q[idx_q] && (rd_tag_q == tag_q);
  assign beat_wr   = (state_q == REFILL_WAIT) && mem_resp_valid;
  assign last_beat = (beat_q == LAST_BEAT);

  assign icache_ready  = (state_q == RESP);
  assign icache_data   = data_q;
  assign mem_req_valid = (state_q == REFILL_REQ);
  assign mem_req_addr  = req_addr_q;

  always_comb begin
    state_d    = state_q;
    tag_d      = tag_q;
    idx_d      = idx_q;
    off_d      = off_q;
    beat_d     = beat_q;
    data_d     = data_q;
    req_addr_d = req_addr_q;
    valid_d    = valid_q;
    case (state_q)
      IDLE: begin
        if (flush) begin
          valid_d = '0;
        end else if (icache_valid) begin
          tag_d   = in_tag;
          idx_d   = in_idx;
          off_d   = in_off;
          state_d = LOOKUP;
        end
      end
      LOOKUP: begin
        if (hit) begin
          data_d  = rd_word_q;
          state_d = RESP;
        end else begin
          req_addr_d = {tag_q, idx_q, {(OFF_W+2){1'b0}}};
          beat_d     = '0;
          state_d    = REFILL_REQ;
        end
      end
      REFILL_REQ: begin
        if (mem_req_ready) state_d = REFILL_WAIT;
      end
      REFILL_WAIT: begin
        if (mem_resp_valid) begin
          beat_d = beat_q + 1'b1;  // wraps to 0 after the last beat
          if (beat_q == off_q) data_d = mem_resp_data;
          if (last_beat) begin
            valid_d[idx_q] = 1'b1;
            state_d        = RESP;
          end
        end
      end
      RESP:    state_d = DRAIN;
      DRAIN:   if (!icache_valid) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      tag_q      <= '0;
      idx_q      <= '0;
      off_q      <= '0;
      beat_q     <= '0;
      data_q     <= '0;
      req_addr_q <= '0;
      valid_q    <= '0;
    end else if (rdy) begin
      state_q    <= state_d;
      tag_q      <= tag_d;
      idx_q      <= idx_d;
      off_q      <= off_d;
      beat_q     <= beat_d;
      data_q     <= data_d;
      req_addr_q <= req_addr_d;
      valid_q    <= valid_d;
    end
  end

  // Synchronous-read arrays: read on request acceptance, result used in LOOKUP.
  // Reads (IDLE) and writes (REFILL_WAIT) never coincide.
  always_ff @(posedge clk) begin
    if (!rst && rdy) begin
      if (accept) begin
        rd_tag_q  <= tag_mem[in_idx];
        rd_word_q <= data_mem[{in_idx, in_off}];
      end
      if (beat_wr) begin
        data_mem[{idx_q, beat_q}] <= mem_resp_data;
        if (last_beat) tag_mem[idx_q] <= tag_q;
      end
    end
  end

`ifdef GELATO_ICACHE_PERF_EN
  logic [31:0] hit_cnt_q, miss_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else if (rdy && state_q == LOOKUP) begin
      if (hit) hit_cnt_q  <= hit_cnt_q + 32'd1;
      else     miss_cnt_q <= miss_cnt_q + 32'd1;
    end
  end

  assign perf_hit_cnt  = hit_cnt_q;
  assign perf_miss_cnt = miss_cnt_q;
`endif

endmodule

// File: tb/tb_gelato_l1_icache.sv
module tb_gelato_l1_icache;
  logic        clk = 1'b0;
  logic        rst, rdy, icache_valid, flush, mem_req_ready, mem_resp_valid;
  logic [31:0] icache_addr, mem_resp_data;
  logic        icache_ready, mem_req_valid;
  logic [31:0] icache_data, mem_req_addr;
`ifdef GELATO_ICACHE_PERF_EN
  logic [31:0] perf_hit_cnt, perf_miss_cnt;
`endif

  int checks = 0;
  int errors = 0;
  int exp_hits = 0;
  int exp_misses = 0;

  gelato_l1_icache dut (
    .clk(clk), .rst(rst), .rdy(rdy),
    .icache_valid(icache_valid), .icache_addr(icache_addr),
    .icache_ready(icache_ready), .icache_data(icache_data),
    .flush(flush),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_req_addr(mem_req_addr),
    .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data)
`ifdef GELATO_ICACHE_PERF_EN
    , .perf_hit_cnt(perf_hit_cnt), .perf_miss_cnt(perf_miss_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Inputs change and outputs are sampled 1 time unit after each rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Hit: ready two edges after the request is first sampled, no memory request.
  // Valid is held 'hold' extra cycles in DRAIN, then dropped for one edge.
  task automatic do_hit(input logic [31:0] addr, input logic [31:0] exp, input int hold);
    icache_valid = 1'b1; icache_addr = addr;
    tick();
    chk("hit_lookup_ready", {31'd0, icache_ready}, 32'd0);
    tick();
    chk("hit_ready", {31'd0, icache_ready}, 32'd1);
    chk("hit_data", icache_data, exp);
    chk("hit_no_memreq", {31'd0, mem_req_valid}, 32'd0);
    tick();
    chk("hit_one_pulse", {31'd0, icache_ready}, 32'd0);
    for (int i = 0; i < hold; i++) begin
      tick();
      chk("drain_hold_ready", {31'd0, icache_ready}, 32'd0);
      chk("drain_hold_memreq", {31'd0, mem_req_valid}, 32'd0);
    end
    icache_valid = 1'b0;
    tick();
    exp_hits++;
  endtask

  // Miss: refill beats are d0+0 .. d0+3; optional request stall, beat gap,
  // and rdy=0 freeze while beat 1 is presented.
  task automatic do_miss(input logic [31:0] addr, input logic [31:0] base,
                         input logic [31:0] d0, input int woff,
                         input int stall, input bit gap, input bit freeze);
    icache_valid = 1'b1; icache_addr = addr;
    tick();
    chk("miss_lookup_memreq", {31'd0, mem_req_valid}, 32'd0);
    tick();
    chk("miss_memreq", {31'd0, mem_req_valid}, 32'd1);
    chk("miss_memaddr", mem_req_addr, base);
    for (int i = 0; i < stall; i++) begin
      tick();
      chk("stall_memreq", {31'd0, mem_req_valid}, 32'd1);
      chk("stall_memaddr", mem_req_addr, base);
    end
    mem_req_ready = 1'b1;
    tick();
    mem_req_ready = 1'b0;
    chk("wait_memreq_low", {31'd0, mem_req_valid}, 32'd0);
    for (int b = 0; b < 4; b++) begin
      if (gap && b == 2) begin
        mem_resp_valid = 1'b0;
        tick();
        chk("gap_ready", {31'd0, icache_ready}, 32'd0);
      end
      mem_resp_valid = 1'b1;
      mem_resp_data  = d0 + b;
      if (freeze && b == 1) begin
        rdy = 1'b0;
        tick();
        tick();
        chk("freeze_ready", {31'd0, icache_ready}, 32'd0);
        rdy = 1'b1;
      end
      tick();
      if (b < 3) chk("beat_ready", {31'd0, icache_ready}, 32'd0);
    end
    mem_resp_valid = 1'b0;
    chk("miss_ready", {31'd0, icache_ready}, 32'd1);
    chk("miss_data", icache_data, d0 + woff);
    tick();
    chk("miss_one_pulse", {31'd0, icache_ready}, 32'd0);
    icache_valid = 1'b0;
    tick();
    exp_misses++;
  endtask

  initial begin
    rst = 1'b1; rdy = 1'b1; icache_valid = 1'b0; icache_addr = '0; flush = 1'b0;
    mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_resp_data = '0;
    tick();
    tick();
    chk("rst_ready", {31'd0, icache_ready}, 32'd0);
    chk("rst_memreq", {31'd0, mem_req_valid}, 32'd0);
    chk("rst_data", icache_data, 32'd0);
    chk("rst_memaddr", mem_req_addr, 32'd0);
`ifdef GELATO_ICACHE_PERF_EN
    chk("rst_perf_hit", perf_hit_cnt, 32'd0);
    chk("rst_perf_miss", perf_miss_cnt, 32'd0);
`endif
    rst = 1'b0;
    tick();

    // Cold miss with a gap between beats.
    do_miss(32'h0000_0104, 32'h0000_0100, 32'hA0, 1, 0, 1'b1, 1'b0);
    // Hits on the refilled line.
    do_hit(32'h0000_010C, 32'hA3, 0);
    do_hit(32'h0000_0100, 32'hA0, 0);
    // Conflict on the same index evicts the line.
    do_miss(32'h0000_1104, 32'h0000_1100, 32'hB0, 1, 0, 1'b0, 1'b0);
    do_hit(32'h0000_1108, 32'hB2, 0);
    // Re-access misses again; memory side stalls the request for 5 cycles.
    do_miss(32'h0000_0104, 32'h0000_0100, 32'hA0, 1, 5, 1'b0, 1'b0);

    // Flush with a concurrent request: request waits one cycle, then misses.
    flush = 1'b1; icache_valid = 1'b1; icache_addr = 32'h0000_0108;
    tick();
    flush = 1'b0;
    chk("flush_ready", {31'd0, icache_ready}, 32'd0);
    chk("flush_memreq", {31'd0, mem_req_valid}, 32'd0);
    do_miss(32'h0000_0108, 32'h0000_0100, 32'hC0, 2, 0, 1'b0, 1'b0);

    // Valid held 3 cycles after ready; back-to-back hit checks DRAIN exit timing.
    do_hit(32'h0000_0108, 32'hC2, 2);
    do_hit(32'h0000_010C, 32'hC3, 0);

    // Refill with rdy=0 while beat 1 is on the bus.
    do_miss(32'h0000_3004, 32'h0000_3000, 32'hE0, 1, 0, 1'b0, 1'b1);
    do_hit(32'h0000_3000, 32'hE0, 0);

    // Reset during REFILL_WAIT.
    icache_valid = 1'b1; icache_addr = 32'h0000_2204;
    tick();
    tick();
    chk("rstmid_memaddr", mem_req_addr, 32'h0000_2200);
    mem_req_ready = 1'b1;
    tick();
    mem_req_ready = 1'b0;
    mem_resp_valid = 1'b1; mem_resp_data = 32'hD0;
    tick();
    mem_resp_data = 32'hD1;
    tick();
    rst = 1'b1; icache_valid = 1'b0; mem_resp_data = 32'hD2;
    tick();
    rst = 1'b0;
    exp_hits = 0; exp_misses = 0;
    chk("rstmid_ready", {31'd0, icache_ready}, 32'd0);
    chk("rstmid_memreq", {31'd0, mem_req_valid}, 32'd0);
    chk("rstmid_data", icache_data, 32'd0);
    mem_resp_data = 32'hD3;
    tick();
    tick();
    mem_resp_valid = 1'b0;
    chk("rstmid_drop_ready", {31'd0, icache_ready}, 32'd0);
    chk("rstmid_drop_memreq", {31'd0, mem_req_valid}, 32'd0);
    // Previously cached line must miss after reset.
    do_miss(32'h0000_0104, 32'h0000_0100, 32'hF0, 1, 0, 1'b0, 1'b0);
    do_hit(32'h0000_0104, 32'hF1, 0);

`ifdef GELATO_ICACHE_PERF_EN
    chk("perf_hit", perf_hit_cnt, exp_hits);
    chk("perf_miss", perf_miss_cnt, exp_misses);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Global time bound so the bench always terminates.
  initial begin
    #200000;
    $display("FAIL timeout: observed no finish expected finish");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/gelato_l1_icache.md
# gelato_l1_icache

Direct-mapped, read-only L1 instruction cache: the responder end of the `gelato_l1_icache_if` fetch protocol.
- Accepts one word-fetch request at a time from the instruction fetch unit.
- Serves hits from local tag/data arrays; refills misses with a line burst from the L2/memory port.
- Returns the 32-bit instruction word with a one-cycle `ready` pulse.

## Interface
Parameters:
- `ADDR_WIDTH`, 32, byte-address width.
- `DATA_WIDTH`, 32, word width (fixed at 32).
- `NUM_LINES`, 64, number of lines; power of two.
- `LINE_WORDS`, 4, words per line; power of two, ≥2.

Ports:
- `clk`  in  1  single clock, all state on rising edge.
- `rst`  in  1  synchronous, active-high reset; has priority over `rdy`.
- `rdy`  in  1  global enable; when 0, all state and outputs hold.
- `icache_valid`  in  1  fetch request (`gelato_l1_icache_if.valid`).
- `icache_addr`  in  ADDR_WIDTH  fetch byte address; bits [1:0] ignored.
- `icache_ready`  out  1  one-cycle response pulse.
- `icache_data`  out  DATA_WIDTH  instruction word; valid while `icache_ready`=1.
- `flush`  in  1  invalidate all lines.
- `mem_req_valid`  out  1  line refill request.
- `mem_req_ready`  in  1  memory accepts request.
- `mem_req_addr`  out  ADDR_WIDTH  line-aligned base address.
- `mem_resp_valid`  in  1  refill beat valid.
- `mem_resp_data`  in  DATA_WIDTH  refill beat, ascending word order.

## Operation
- Address split: `off = addr[log2(LINE_WORDS)+1:2]`; `idx` = next log2(NUM_LINES) bits; `tag` = remaining upper bits.
- Arrays are per-line valid bits, tags and data, with registered (synchronous) read.
- FSM states: IDLE, LOOKUP, REFILL_REQ, REFILL_WAIT, RESP, DRAIN.
  - IDLE:
    - If `flush`=1, clear all valid bits and stay in IDLE, even if `icache_valid`=1; the request is taken next cycle.
    - Otherwise, if `icache_valid`=1, latch `icache_addr` and go to LOOKUP.
  - LOOKUP: hit (valid and tag equal) → RESP with the array word; miss → REFILL_REQ.
  - REFILL_REQ:
    - Drive `mem_req_valid`=1 with `mem_req_addr = {tag, idx, 0...}`.
    - Hold until `mem_req_ready`=1, then go to REFILL_WAIT.
  - REFILL_WAIT:
    - On each `mem_resp_valid` beat, write word `beat_cnt` into the line and increment `beat_cnt`; gaps between beats are allowed.
    - Capture the beat where `beat_cnt == off` as the response word.
    - On the last beat (`beat_cnt == LINE_WORDS-1`), set the tag and valid bit and go to RESP.
  - RESP: `icache_ready`=1 and `icache_data` = word for exactly one cycle, then DRAIN.
  - DRAIN: wait for `icache_valid`=0, then IDLE. This prevents re-serving a request the fetch unit still holds for a cycle after `ready`.
- Requester contract: hold `icache_addr` stable while `icache_valid`=1; deassert for at least one cycle between requests.
- `flush` outside IDLE is ignored and not latched; only the valid bits change on flush.
- `mem_resp_valid` outside REFILL_WAIT is ignored.
- `beat_cnt` is log2(LINE_WORDS) bits, wraps to 0 after the last beat, and is cleared on entry to REFILL_REQ.

## Timing
- Reset values:
  - FSM in IDLE.
  - All line valid bits 0.
  - `icache_ready`, `mem_req_valid` = 0.
  - `icache_data`, `mem_req_addr` = 0.
  - `beat_cnt` = 0.
  - Perf counters 0.
- Hit latency: `icache_valid` first sampled high at edge N → `icache_ready` high in cycle N+2.
- Miss latency: `mem_req_valid` high in cycle N+2; last refill beat at edge M → `icache_ready` high in cycle M+1.
- Reset asserted mid-refill: FSM goes to IDLE, all valid bits clear, and remaining memory beats are dropped.
- With `rdy`=0, the FSM, counters, arrays and outputs freeze; an in-flight `mem_resp_valid` beat is not captured. The memory side must hold the beat.

## Configuration
- `GELATO_ICACHE_PERF_EN` defined: adds output ports `perf_hit_cnt` and `perf_miss_cnt`, 32 bits each.
  - They increment once per LOOKUP hit and once per LOOKUP miss respectively.
  - They wrap modulo 2^32 and are cleared by `rst` only, not by `flush`.
- `GELATO_ICACHE_PERF_EN` undefined: these ports and their counters do not exist, and behaviour is otherwise identical.

## Test plan
- Cold miss at 0x0000_0104:
  - `mem_req_addr`=0x0000_0100.
  - Beats 0xA0, 0xA1, 0xA2, 0xA3 → `icache_data`=0xA1 one cycle after the last beat.
- Hit after refill at 0x0000_010C → `icache_ready` at N+2 with 0xA3 and no `mem_req_valid`.
- Conflict: 0x0000_0104 then 0x0000_1104, same idx with NUM_LINES=64 and LINE_WORDS=4.
  - Second access refills from 0x0000_1100.
  - Re-access of 0x0000_0104 misses again.
- `flush` together with `icache_valid` in IDLE → request starts one cycle later and misses on a previously cached line.
- `icache_valid` held 3 cycles after `ready` → exactly one `ready` pulse; DRAIN exits on the cycle `icache_valid` drops.
- Stall and reset cases:
  - `mem_req_ready` low 5 cycles → `mem_req_valid` and `mem_req_addr` stay stable.
  - `rst` pulsed in REFILL_WAIT → IDLE, and the next access to the same line misses.
